// File: rtl/utf8_pkg.sv
// Shared constants and encodings for the UTF-8 decode/encode path.
// Holds the code-point limits, the decoder state enum and the lead-byte classes.
package utf8_pkg;

   localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
   localparam logic [20:0] MAX_CP         = 21'h10FFFF;
   localparam logic [20:0] SURR_LO        = 21'h00D800;
   localparam logic [20:0] SURR_HI        = 21'h00DFFF;

   typedef enum logic {
      IDLE,
      CONT
   } state_e;

   typedef enum logic [2:0] {
      ASCII,
      LEAD2,
      LEAD3,
      LEAD4,
      CONT_BYTE,
      INVALID
   } lead_class_e;

endpackage

// File: rtl/utf8_lead_classify.sv
// Combinational UTF-8 code-unit classifier: class, payload bits and sequence length.
// Shared between the decoder and the encoder-side checks.
module utf8_lead_classify
   import utf8_pkg::*;
(
   input  logic [7:0]  i_byte,
   output lead_class_e o_class,
   output logic [6:0]  o_payload,
   output logic [2:0]  o_len
);

   always_comb begin
      o_class   = INVALID;
      o_payload = '0;
      o_len     = 3'd1;
      if (!i_byte[7]) begin
         o_class   = ASCII;
         o_payload = i_byte[6:0];
      end else if (i_byte[7:6] == 2'b10) begin
         o_class   = CONT_BYTE;
         o_payload = {1'b0, i_byte[5:0]};
      end else if (i_byte[7:5] == 3'b110) begin
         o_class   = LEAD2;
         o_payload = {2'b0, i_byte[4:0]};
         o_len     = 3'd2;
      end else if (i_byte[7:4] == 4'b1110) begin
         o_class   = LEAD3;
         o_payload = {3'b0, i_byte[3:0]};
         o_len     = 3'd3;
      end else if (i_byte[7:3] == 5'b11110) begin
         o_class   = LEAD4;
         o_payload = {4'b0, i_byte[2:0]};
         o_len     = 3'd4;
      end
   end

endmodule

// File: rtl/utf8_stream_decoder.sv
// Byte-serial UTF-8 decoder: reassembles code units into 21-bit scalar values,
// substituting U+FFFD for malformed or truncated input.
module utf8_stream_decoder
   import utf8_pkg::*;
#(
   parameter bit STRICT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [20:0] out_cp,
   output logic        out_err,
   output logic [2:0]  out_len
);

   state_e      r_state, w_state_d;
   logic [1:0]  r_rem, w_rem_d;
   logic [2:0]  r_cnt, w_cnt_d;
   logic [2:0]  r_len, w_len_d;
   logic [20:0] r_acc, w_acc_d;

   logic        r_out_valid;
   logic [20:0] r_out_cp;
   logic        r_out_err;
   logic [2:0]  r_out_len;

   lead_class_e w_class;
   logic [6:0]  w_payload;
   logic [2:0]  w_len;
   logic [2:0]  w_len_m1;
   logic [20:0] w_acc_shift;
   logic        w_slot_free, w_trunc, w_fire, w_chk_err;
   logic        w_emit, w_emit_err;
   logic [20:0] w_emit_cp;
   logic [2:0]  w_emit_len;

   utf8_lead_classify u_classify (
      .i_byte    (in_byte),
      .o_class   (w_class),
      .o_payload (w_payload),
      .o_len     (w_len)
   );

   assign w_len_m1    = w_len - 3'd1;
   assign w_acc_shift = {r_acc[14:0], in_byte[5:0]};
   assign w_slot_free = !r_out_valid || out_ready;
   // A non-continuation byte in CONT ends the sequence but is left for IDLE to re-classify.
   assign w_trunc     = (r_state == CONT) && in_valid && (w_class != CONT_BYTE);
   assign in_ready    = w_slot_free && !w_trunc;
   assign w_fire      = in_valid && in_ready;

   always_comb begin
      w_chk_err = 1'b0;
      if (STRICT) begin
         unique case (r_len)
            3'd2:    w_chk_err = (w_acc_shift < 21'h000080);
            3'd3:    w_chk_err = (w_acc_shift < 21'h000800);
            3'd4:    w_chk_err = (w_acc_shift < 21'h010000) || (w_acc_shift > MAX_CP);
            default: w_chk_err = 1'b0;
         endcase
         if ((w_acc_shift >= SURR_LO) && (w_acc_shift <= SURR_HI)) begin
            w_chk_err = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_rem_d    = r_rem;
      w_cnt_d    = r_cnt;
      w_len_d    = r_len;
      w_acc_d    = r_acc;
      w_emit     = 1'b0;
      w_emit_cp  = '0;
      w_emit_err = 1'b0;
      w_emit_len = '0;
      unique case (r_state)
         IDLE: begin
            if (w_fire) begin
               unique case (w_class)
                  ASCII: begin
                     w_emit     = 1'b1;
                     w_emit_cp  = {14'b0, w_payload};
                     w_emit_len = 3'd1;
                  end
                  LEAD2, LEAD3, LEAD4: begin
                     w_state_d = CONT;
                     w_acc_d   = {14'b0, w_payload};
                     w_rem_d   = w_len_m1[1:0];
                     w_cnt_d   = 3'd1;
                     w_len_d   = w_len;
                  end
                  default: begin
                     w_emit     = 1'b1;
                     w_emit_cp  = REPLACEMENT_CP;
                     w_emit_err = 1'b1;
                     w_emit_len = 3'd1;
                  end
               endcase
            end
         end
         CONT: begin
            if (w_trunc && w_slot_free) begin
               w_emit     = 1'b1;
               w_emit_cp  = REPLACEMENT_CP;
               w_emit_err = 1'b1;
               w_emit_len = r_cnt;
               w_state_d  = IDLE;
               w_rem_d    = '0;
               w_cnt_d    = '0;
               w_len_d    = '0;
               w_acc_d    = '0;
            end else if (w_fire) begin
               w_acc_d = w_acc_shift;
               w_cnt_d = r_cnt + 3'd1;
               w_rem_d = r_rem - 2'd1;
               if (r_rem == 2'd1) begin
                  w_emit     = 1'b1;
                  w_emit_err = w_chk_err;
                  w_emit_cp  = w_chk_err ? REPLACEMENT_CP : w_acc_shift;
                  w_emit_len = r_len;
                  w_state_d  = IDLE;
                  w_rem_d    = '0;
                  w_cnt_d    = '0;
                  w_len_d    = '0;
                  w_acc_d    = '0;
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_d;
         r_rem   <= w_rem_d;
         r_cnt   <= w_cnt_d;
         r_len   <= w_len_d;
         r_acc   <= w_acc_d;
      end
   end

   // Emission only happens with a free slot, so loading here never overwrites an unread result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_cp    <= '0;
         r_out_err   <= 1'b0;
         r_out_len   <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_cp    <= w_emit_cp;
         r_out_err   <= w_emit_err;
         r_out_len   <= w_emit_len;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_cp    = r_out_cp;
   assign out_err   = r_out_err;
   assign out_len   = r_out_len;

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Scoreboard bench for utf8_stream_decoder: strict and lax instances share one
// input stream; a monitor pops expected results whenever an output transfers.
module tb_utf8_stream_decoder;

   typedef struct packed {
      logic [20:0] cp;
      logic        err;
      logic [2:0]  len;
   } res_t;

   res_t q_s[$];
   res_t q_l[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        out_ready;

   logic        s_in_ready, s_out_valid, s_out_err;
   logic [20:0] s_out_cp;
   logic [2:0]  s_out_len;
   logic        l_in_ready, l_out_valid, l_out_err;
   logic [20:0] l_out_cp;
   logic [2:0]  l_out_len;

   always #5 clk = ~clk;

   utf8_stream_decoder #(.STRICT(1'b1)) u_dut_strict (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .in_byte   (in_byte),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out_cp    (s_out_cp),
      .out_err   (s_out_err),
      .out_len   (s_out_len)
   );

   utf8_stream_decoder #(.STRICT(1'b0)) u_dut_lax (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (l_in_ready),
      .in_byte   (in_byte),
      .out_valid (l_out_valid),
      .out_ready (out_ready),
      .out_cp    (l_out_cp),
      .out_err   (l_out_err),
      .out_len   (l_out_len)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic res_t mk(input logic [20:0] cp, input logic err, input logic [2:0] len);
      mk.cp  = cp;
      mk.err = err;
      mk.len = len;
   endfunction

   task automatic push(input res_t s, input res_t l);
      q_s.push_back(s);
      q_l.push_back(l);
   endtask

   task automatic push_both(input res_t r);
      push(r, r);
   endtask

   // Monitor: one comparison set per output transfer.
   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         if (s_out_valid && out_ready) begin
            if (q_s.size() == 0) check("strict_unexpected_result", 32'd1, 32'd0);
            else begin
               e = q_s.pop_front();
               check("strict_cp", 32'(s_out_cp), 32'(e.cp));
               check("strict_err", 32'(s_out_err), 32'(e.err));
               check("strict_len", 32'(s_out_len), 32'(e.len));
            end
         end
         if (l_out_valid && out_ready) begin
            if (q_l.size() == 0) check("lax_unexpected_result", 32'd1, 32'd0);
            else begin
               e = q_l.pop_front();
               check("lax_cp", 32'(l_out_cp), 32'(e.cp));
               check("lax_err", 32'(l_out_err), 32'(e.err));
               check("lax_len", 32'(l_out_len), 32'(e.len));
            end
         end
      end
   end

   // Present a byte, wait (bounded) for the transfer; returns stalled cycles.
   task automatic send(input logic [7:0] b, output int stalls);
      stalls   = 0;
      in_valid = 1'b1;
      in_byte  = b;
      forever begin
         @(negedge clk);
         if (s_in_ready != l_in_ready) check("ready_agree", 32'(l_in_ready), 32'(s_in_ready));
         if (s_in_ready && l_in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         stalls++;
         if (stalls > 50) begin
            $display("FAIL send_timeout: byte %0h never accepted", b);
            $fatal(1, "send timeout");
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int n);
      int st;
      send(b0, st);
      if (n > 1) send(b1, st);
      if (n > 2) send(b2, st);
      if (n > 3) send(b3, st);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_s.size() != 0 || q_l.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", 32'(q_s.size() + q_l.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st, tot;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_out_valid", 32'(s_out_valid), 32'd0);
      check("rst_out_cp", 32'(s_out_cp), 32'd0);
      check("rst_out_err", 32'(s_out_err), 32'd0);
      check("rst_out_len", 32'(s_out_len), 32'd0);
      check("rst_in_ready", 32'(s_in_ready), 32'd1);
      check("rst_in_ready_lax", 32'(l_in_ready), 32'd1);
      @(posedge clk);
      #1;

      // ASCII, one-cycle latency
      push_both(mk(21'h41, 1'b0, 3'd1));
      send(8'h41, st);
      @(negedge clk);
      check("ascii_latency", 32'(s_out_valid), 32'd1);
      drain();

      // Stream at full rate
      push_both(mk(21'h41, 1'b0, 3'd1));
      push_both(mk(21'h42, 1'b0, 3'd1));
      push_both(mk(21'h43, 1'b0, 3'd1));
      tot = 0;
      send(8'h41, st); tot += st;
      send(8'h42, st); tot += st;
      send(8'h43, st); tot += st;
      check("ascii_stream_stalls", 32'(tot), 32'd0);
      drain();

      // Multi-byte
      push_both(mk(21'h0020AC, 1'b0, 3'd3));
      send_seq(8'hE2, 8'h82, 8'hAC, 8'h00, 3);
      push_both(mk(21'h01F600, 1'b0, 3'd4));
      send_seq(8'hF0, 8'h9F, 8'h98, 8'h80, 4);
      drain();

      // Backpressure on a held result
      out_ready = 1'b0;
      push_both(mk(21'h01F600, 1'b0, 3'd4));
      send_seq(8'hF0, 8'h9F, 8'h98, 8'h80, 4);
      in_valid = 1'b1;
      in_byte  = 8'h41;
      repeat (3) begin
         @(negedge clk);
         check("bp_out_valid", 32'(s_out_valid), 32'd1);
         check("bp_out_cp", 32'(s_out_cp), 32'h01F600);
         check("bp_out_len", 32'(s_out_len), 32'd4);
         check("bp_in_ready", 32'(s_in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Overlong and out-of-range
      push(mk(21'h00FFFD, 1'b1, 3'd2), mk(21'h000000, 1'b0, 3'd2));
      send_seq(8'hC0, 8'h80, 8'h00, 8'h00, 2);
      push(mk(21'h00FFFD, 1'b1, 3'd4), mk(21'h110000, 1'b0, 3'd4));
      send_seq(8'hF4, 8'h90, 8'h80, 8'h80, 4);
      drain();

      // Truncation: 41 stalls once, then is decoded on its own
      push_both(mk(21'h00FFFD, 1'b1, 3'd2));
      push_both(mk(21'h000041, 1'b0, 3'd1));
      send(8'hE2, st);
      send(8'h82, st);
      send(8'h41, st);
      check("trunc_stall", 32'(st), 32'd1);
      drain();

      // Surrogate, stray continuation, invalid lead
      push(mk(21'h00FFFD, 1'b1, 3'd3), mk(21'h00D800, 1'b0, 3'd3));
      send_seq(8'hED, 8'hA0, 8'h80, 8'h00, 3);
      push_both(mk(21'h00FFFD, 1'b1, 3'd1));
      send(8'h80, st);
      push_both(mk(21'h00FFFD, 1'b1, 3'd1));
      send(8'hFF, st);
      drain();

      // Reset mid-sequence discards the partial sequence
      send(8'hE2, st);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", 32'(s_out_valid), 32'd0);
      @(posedge clk);
      #1;
      push_both(mk(21'h000041, 1'b0, 3'd1));
      send(8'h41, st);
      drain();

      repeat (5) @(negedge clk);
      check("no_extra_results", 32'(q_s.size() + q_l.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
